// File: rtl/multicycle_control_unit_if.sv
// Bus between the multicycle control unit and the surrounding datapath/memory.
interface multicycle_control_unit_if #(
   parameter int OP     = 4,
   parameter int ULA_OP = 3,
   parameter int CNT_W  = 16
) ();
   logic [OP-1:0]     op;
   logic              zero;
   logic              mem_ready;
   logic              mem_req;
   logic              ir_we;
   logic              pc_we;
   logic [0:9]        signals;
   logic [ULA_OP-1:0] ula_op;
   logic [2:0]        state;
   logic [CNT_W-1:0]  instret;
   logic              illegal;

   modport master (
      input  op, zero, mem_ready,
      output mem_req, ir_we, pc_we, signals, ula_op, state, instret, illegal
   );

   modport slave (
      output op, zero, mem_ready,
      input  mem_req, ir_we, pc_we, signals, ula_op, state, instret, illegal
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle REDUX-V control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with phase-gated controls.
// Define ILLEGAL_TRAP_EN to trap undefined opcodes into HALT instead of running them as NOPs.
module multicycle_control_unit #(
   parameter int OP     = 4,
   parameter int ULA_OP = 3,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   multicycle_control_unit_if.master bus
);
   // states: FETCH=ifetch wait | DECODE=latch op | EXEC | MEM=data wait | WB | HALT=trap
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam int BR = 0, J = 1, RA = 2, RE = 3, DM = 4, WE = 5, SE = 6, SP = 7, SPR = 8;

   localparam logic [3:0] OP_BRZR = 4'd0, OP_JI   = 4'd1, OP_LD  = 4'd2, OP_ST  = 4'd3;
   localparam logic [3:0] OP_ADDI = 4'd4, OP_PUSH = 4'd5, OP_POP = 4'd6, OP_NOT = 4'd8;
   localparam logic [3:0] OP_ADD  = 4'd12;

   localparam logic [0:9] HOLD_MASK = 10'b0010001110;
   localparam logic [0:9] EXEC_MASK = HOLD_MASK | 10'b1100000000;
   localparam logic [0:9] MEM_MASK  = HOLD_MASK | 10'b0000110000;
   localparam logic [0:9] WB_MASK   = HOLD_MASK | 10'b0001000000;

   state_t            state_q, state_d;
   logic [OP-1:0]     op_q, op_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic [3:0]        op_lo;
   logic              op_undef;
   logic [0:9]        dec;
   logic [0:9]        gate;
   logic [ULA_OP-1:0] ula_val;
   logic              ula_en;
   logic              mem_req, ir_we, pc_we;

   assign op_lo = op_q[3:0];

   if (OP > 4) begin : g_wide_op
      assign op_undef = |op_q[OP-1:4];
   end else begin : g_narrow_op
      assign op_undef = 1'b0;
   end

   always_comb begin
      dec = '0;
      if (!op_undef) begin
         case (op_lo)
            OP_BRZR: dec[BR] = 1'b1;
            OP_JI:   dec[J]  = 1'b1;
            OP_LD:   begin dec[RA] = 1'b1; dec[RE] = 1'b1; dec[DM] = 1'b1; end
            OP_ST:   dec[WE] = 1'b1;
            OP_ADDI: begin dec[RA] = 1'b1; dec[SE] = 1'b1; dec[RE] = 1'b1; end
            OP_PUSH: begin
               dec[RA] = 1'b1; dec[RE] = 1'b1; dec[WE] = 1'b1; dec[DM] = 1'b1; dec[SP] = 1'b1;
            end
            OP_POP:  begin dec[RE] = 1'b1; dec[DM] = 1'b1; dec[SP] = 1'b1; dec[SPR] = 1'b1; end
            default: dec[RE] = 1'b1;
         endcase
      end
   end

   always_comb begin
      ula_val = '0;
      if (!op_undef) begin
         if (op_lo == OP_ADDI) ula_val = OP_ADD[ULA_OP-1:0];
         else if (op_lo >= OP_NOT) ula_val = op_q[ULA_OP-1:0];
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      instret_d = instret_q;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      mem_req   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      gate      = '0;
      ula_en    = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            op_d    = bus.op;
            state_d = EXEC;
         end
         EXEC: begin
            gate   = EXEC_MASK;
            ula_en = 1'b1;
            if (op_undef) begin
`ifdef ILLEGAL_TRAP_EN
               state_d   = HALT;
               illegal_d = 1'b1;
`else
               state_d = FETCH;
`endif
            end else if (dec[BR]) begin
               pc_we   = bus.zero;
               state_d = FETCH;
            end else if (dec[J]) begin
               pc_we   = 1'b1;
               state_d = FETCH;
            end else if (dec[DM] | dec[WE]) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            mem_req = 1'b1;
            gate    = MEM_MASK;
            ula_en  = 1'b1;
            if (bus.mem_ready) state_d = dec[RE] ? WB : FETCH;
         end
         WB: begin
            gate    = WB_MASK;
            ula_en  = 1'b1;
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
      if (state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB))
         instret_d = instret_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         op_q      <= '0;
         instret_q <= '0;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         instret_q <= instret_d;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // reset blanks every output immediately, even before the first clock edge
   assign bus.mem_req = mem_req & ~rst;
   assign bus.ir_we   = ir_we & ~rst;
   assign bus.pc_we   = pc_we & ~rst;
   assign bus.signals = rst ? '0 : (dec & gate);
   assign bus.ula_op  = (rst || !ula_en) ? '0 : ula_val;
   assign bus.state   = rst ? 3'd0 : state_q;
   assign bus.instret = rst ? '0 : instret_q;
`ifdef ILLEGAL_TRAP_EN
   assign bus.illegal = illegal_q & ~rst;
`else
   assign bus.illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit (OP=4 main instance, OP=5 undefined-op instance).
module tb_multicycle_control_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;

   multicycle_control_unit_if #(.OP(4), .ULA_OP(3), .CNT_W(16)) bus_a ();
   multicycle_control_unit_if #(.OP(5), .ULA_OP(3), .CNT_W(16)) bus_b ();

   multicycle_control_unit #(.OP(4), .ULA_OP(3), .CNT_W(16)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
   multicycle_control_unit #(.OP(5), .ULA_OP(3), .CNT_W(16)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

   localparam logic [0:9] S_BR  = 10'b1000000000;
   localparam logic [0:9] S_J   = 10'b0100000000;
   localparam logic [0:9] S_RA  = 10'b0010000000;
   localparam logic [0:9] S_RE  = 10'b0001000000;
   localparam logic [0:9] S_DM  = 10'b0000100000;
   localparam logic [0:9] S_WE  = 10'b0000010000;
   localparam logic [0:9] S_SE  = 10'b0000001000;
   localparam logic [0:9] S_SP  = 10'b0000000100;
   localparam logic [0:9] S_SPR = 10'b0000000010;
   localparam logic [0:9] NONE  = 10'b0000000000;

   typedef struct {
      string       tag;
      logic        rst;
      logic [3:0]  op;
      logic        zero;
      logic        rdy;
      logic [35:0] exp;
   } vec_t;

   vec_t sbq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // one entry per clock: inputs to drive plus {state,mem_req,ir_we,pc_we,signals,ula_op,instret,illegal}
   task automatic exp_cyc(input string tag, input logic r, input logic [3:0] op, input logic z,
                          input logic rdy, input logic [2:0] st, input logic req, input logic irw,
                          input logic pcw, input logic [0:9] sig, input logic [2:0] ula,
                          input logic [15:0] ir);
      vec_t v;
      v.tag  = tag;
      v.rst  = r;
      v.op   = op;
      v.zero = z;
      v.rdy  = rdy;
      v.exp  = {st, req, irw, pcw, sig, ula, ir, 1'b0};
      sbq.push_back(v);
   endtask

   task automatic drain();
      vec_t        v;
      logic [35:0] got;
      while (sbq.size() > 0) begin
         v = sbq.pop_front();
         rst_a           = v.rst;
         bus_a.op        = v.op;
         bus_a.zero      = v.zero;
         bus_a.mem_ready = v.rdy;
         @(negedge clk);
         got = {bus_a.state, bus_a.mem_req, bus_a.ir_we, bus_a.pc_we, bus_a.signals,
                bus_a.ula_op, bus_a.instret, bus_a.illegal};
         n_vec++;
         assert (got === v.exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", v.tag, got, v.exp);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.op = '0; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b0;
      bus_b.op = 5'h10; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b1;
      #1;

      exp_cyc("rst0", 1, 4'd0, 0, 0, 3'd0, 0, 0, 0, NONE, 3'd0, 16'd0);
      exp_cyc("rst1", 1, 4'd0, 0, 1, 3'd0, 0, 0, 0, NONE, 3'd0, 16'd0);

      exp_cyc("add_f", 0, 4'd12, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd0);
      exp_cyc("add_d", 0, 4'd12, 0, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd0);
      exp_cyc("add_e", 0, 4'd12, 0, 1, 3'd2, 0, 0, 0, NONE, 3'd4, 16'd0);
      exp_cyc("add_w", 0, 4'd12, 0, 1, 3'd4, 0, 0, 0, S_RE, 3'd4, 16'd0);

      exp_cyc("brz0_f", 0, 4'd0, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd1);
      exp_cyc("brz0_d", 0, 4'd0, 0, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd1);
      exp_cyc("brz0_e", 0, 4'd0, 0, 1, 3'd2, 0, 0, 0, S_BR, 3'd0, 16'd1);
      exp_cyc("brz1_f", 0, 4'd0, 1, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd2);
      exp_cyc("brz1_d", 0, 4'd0, 1, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd2);
      exp_cyc("brz1_e", 0, 4'd0, 1, 1, 3'd2, 0, 0, 1, S_BR, 3'd0, 16'd2);

      exp_cyc("push_f", 0, 4'd5, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd3);
      exp_cyc("push_d", 0, 4'd5, 0, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd3);
      exp_cyc("push_e", 0, 4'd5, 0, 1, 3'd2, 0, 0, 0, S_RA | S_SP, 3'd0, 16'd3);
      for (int i = 0; i < 3; i++)
         exp_cyc("push_mwait", 0, 4'd5, 0, 0, 3'd3, 1, 0, 0, S_RA | S_SP | S_DM | S_WE, 3'd0, 16'd3);
      exp_cyc("push_m", 0, 4'd5, 0, 1, 3'd3, 1, 0, 0, S_RA | S_SP | S_DM | S_WE, 3'd0, 16'd3);
      exp_cyc("push_w", 0, 4'd5, 0, 1, 3'd4, 0, 0, 0, S_RA | S_SP | S_RE, 3'd0, 16'd3);

      exp_cyc("ld_fwait", 0, 4'd2, 0, 0, 3'd0, 1, 0, 0, NONE, 3'd0, 16'd4);
      exp_cyc("ld_f", 0, 4'd2, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd4);
      exp_cyc("ld_d", 0, 4'd2, 0, 0, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd4);
      exp_cyc("ld_e", 0, 4'd2, 0, 1, 3'd2, 0, 0, 0, S_RA, 3'd0, 16'd4);
      exp_cyc("ld_m", 0, 4'd2, 0, 1, 3'd3, 1, 0, 0, S_RA | S_DM, 3'd0, 16'd4);
      exp_cyc("ld_w", 0, 4'd2, 0, 1, 3'd4, 0, 0, 0, S_RA | S_RE, 3'd0, 16'd4);

      exp_cyc("addi_f", 0, 4'd4, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd5);
      exp_cyc("addi_d", 0, 4'd4, 0, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd5);
      exp_cyc("addi_e", 0, 4'd4, 0, 1, 3'd2, 0, 0, 0, S_RA | S_SE, 3'd4, 16'd5);
      exp_cyc("addi_w", 0, 4'd4, 0, 1, 3'd4, 0, 0, 0, S_RA | S_SE | S_RE, 3'd4, 16'd5);

      exp_cyc("pop_f", 0, 4'd6, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd6);
      exp_cyc("pop_d", 0, 4'd6, 0, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd6);
      exp_cyc("pop_e", 0, 4'd6, 0, 1, 3'd2, 0, 0, 0, S_SP | S_SPR, 3'd0, 16'd6);
      exp_cyc("pop_m", 0, 4'd6, 0, 1, 3'd3, 1, 0, 0, S_DM | S_SP | S_SPR, 3'd0, 16'd6);
      exp_cyc("pop_w", 0, 4'd6, 0, 1, 3'd4, 0, 0, 0, S_RE | S_SP | S_SPR, 3'd0, 16'd6);

      exp_cyc("ji_f", 0, 4'd1, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd7);
      exp_cyc("ji_d", 0, 4'd1, 0, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd7);
      exp_cyc("ji_e", 0, 4'd1, 0, 1, 3'd2, 0, 0, 1, S_J, 3'd0, 16'd7);

      exp_cyc("srr_f", 0, 4'd15, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd8);
      exp_cyc("srr_d", 0, 4'd15, 0, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd8);
      exp_cyc("srr_e", 0, 4'd15, 0, 1, 3'd2, 0, 0, 0, NONE, 3'd7, 16'd8);
      exp_cyc("srr_w", 0, 4'd15, 0, 1, 3'd4, 0, 0, 0, S_RE, 3'd7, 16'd8);

      exp_cyc("st_f", 0, 4'd3, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd9);
      exp_cyc("st_d", 0, 4'd3, 0, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd9);
      exp_cyc("st_e", 0, 4'd3, 0, 1, 3'd2, 0, 0, 0, NONE, 3'd0, 16'd9);
      exp_cyc("st_mwait1", 0, 4'd3, 0, 0, 3'd3, 1, 0, 0, S_WE, 3'd0, 16'd9);
      exp_cyc("st_rst", 1, 4'd3, 0, 0, 3'd0, 0, 0, 0, NONE, 3'd0, 16'd0);

      // op changes after DECODE must not disturb the instruction in flight
      exp_cyc("post_f", 0, 4'd12, 0, 1, 3'd0, 1, 1, 1, NONE, 3'd0, 16'd0);
      exp_cyc("post_d", 0, 4'd12, 0, 1, 3'd1, 0, 0, 0, NONE, 3'd0, 16'd0);
      exp_cyc("post_e", 0, 4'd3, 0, 1, 3'd2, 0, 0, 0, NONE, 3'd4, 16'd0);
      exp_cyc("post_w", 0, 4'd3, 0, 1, 3'd4, 0, 0, 0, S_RE, 3'd4, 16'd0);
      exp_cyc("post_f2", 0, 4'd3, 0, 0, 3'd0, 1, 0, 0, NONE, 3'd0, 16'd1);

      drain();

      rst_b = 1'b0;
      @(negedge clk);
      chk("b_fetch_state", 32'(bus_b.state), 32'd0);
      chk("b_fetch_req", 32'(bus_b.mem_req), 32'd1);
      next_cyc();
      @(negedge clk);
      chk("b_decode_state", 32'(bus_b.state), 32'd1);
      next_cyc();
      @(negedge clk);
      chk("b_exec_state", 32'(bus_b.state), 32'd2);
      chk("b_exec_sig", 32'(bus_b.signals), 32'd0);
      chk("b_exec_pcwe", 32'(bus_b.pc_we), 32'd0);
      chk("b_exec_ula", 32'(bus_b.ula_op), 32'd0);
      next_cyc();
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("b_halt_state", 32'(bus_b.state), 32'd5);
         chk("b_halt_illegal", 32'(bus_b.illegal), 32'd1);
         chk("b_halt_req", 32'(bus_b.mem_req), 32'd0);
         chk("b_halt_instret", 32'(bus_b.instret), 32'd0);
         next_cyc();
      end
      rst_b = 1'b1;
      @(negedge clk);
      chk("b_rst_illegal", 32'(bus_b.illegal), 32'd0);
      next_cyc();
      rst_b = 1'b0;
      @(negedge clk);
      chk("b_after_rst_state", 32'(bus_b.state), 32'd0);
      chk("b_after_rst_req", 32'(bus_b.mem_req), 32'd1);
      chk("b_after_rst_illegal", 32'(bus_b.illegal), 32'd0);
`else
      @(negedge clk);
      chk("b_nop_state", 32'(bus_b.state), 32'd0);
      chk("b_nop_instret", 32'(bus_b.instret), 32'd1);
      chk("b_nop_illegal", 32'(bus_b.illegal), 32'd0);
      chk("b_nop_req", 32'(bus_b.mem_req), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
